// File: rtl/uart_pkg.sv
// Shared UART frame definitions, used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int   DATA_BITS  = 8;
    localparam int   STOP_BITS  = 1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the async input through two flops to settle metastability.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_byte_receiver.sv
// UART 8N1 byte receiver with a valid/ready output and overrun reporting.
// Optional stop-bit framing check: define UART_RX_FRAMING_CHECK_EN.
module uart_byte_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 10_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic                 overrun,
    output logic                 framing_error
);

    localparam int BIT_CYCLES  = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CNT_W       = $clog2(BIT_CYCLES + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 rx;
    uart_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 stop_done;
    logic                 byte_ok;

    sync_2ff #(.RST_VAL(IDLE_LEVEL)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (serial_in),
        .q   (rx)
    );

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Next-state: half-bit start check, then full-bit samples mid-cell, LSB first.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        stop_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx == 1'b0) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A high line at mid-start is a glitch, not a frame.
                    state_d = rx ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    shift_d[idx_q] = rx;
                    cnt_d          = '0;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == IDX_LAST) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    // Back to IDLE unconditionally so a following start bit is never missed.
                    stop_done = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_RX_FRAMING_CHECK_EN
    logic fe_q;
    assign byte_ok       = stop_done && rx;
    assign framing_error = fe_q;

    // Pulse framing_error for one cycle on a low stop bit.
    always_ff @(posedge clk) begin
        if (rst) fe_q <= 1'b0;
        else     fe_q <= stop_done && !rx;
    end
`else
    assign byte_ok       = stop_done;
    assign framing_error = 1'b0;
`endif

    // Output holding register: load when empty or being consumed, else drop and flag overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (byte_ok) begin
                if (!data_out_valid || data_out_ready) begin
                    data_out       <= shift_q;
                    data_out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_out_valid && data_out_ready) begin
                data_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver at 50 MHz / 10 Mbaud (5 clocks per bit).
module tb_uart_byte_receiver;

    localparam int BITC = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       overrun;
    logic       framing_error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs_cnt = 0;
    int hs_cyc = 0;
    int ovr_cnt = 0;
    int fe_cnt  = 0;
    logic [7:0] exp_q[$];

    uart_byte_receiver #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(10_000_000)) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .overrun        (overrun),
        .framing_error  (framing_error)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted byte is compared to the oldest expected one.
    always @(negedge clk) begin
        if (!rst) begin
            if (overrun) ovr_cnt++;
            if (framing_error) fe_cnt++;
            if (data_out_valid && data_out_ready) begin
                hs_cnt++;
                hs_cyc = cyc;
                if (exp_q.size() == 0) check("unexpected_byte", int'(data_out), -1);
                else check("byte", int'(data_out), int'(exp_q.pop_front()));
            end
        end
    end

    // Drive the first nbits of frame {stop, data, start}, LSB first.
    task automatic send_bits(input logic [7:0] b, input logic stopb, input int nbits);
        logic [9:0] frame;
        frame = {stopb, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            serial_in = frame[i];
            repeat (BITC) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drained(input string tag, input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        int t0, hs0, ovr0, fe0;
        logic seen;
        rst = 1'b1;
        serial_in = 1'b1;
        data_out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_data", int'(data_out), 0);
        check("rst_valid", int'(data_out_valid), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_framing", int'(framing_error), 0);
        rst = 1'b0;
        idle(5);

        // Single byte, latency from the start edge.
        t0 = cyc;
        hs0 = hs_cnt;
        exp_q.push_back(8'h61);
        send_bits(8'h61, 1'b1, 10);
        idle(10);
        check("single_hs", hs_cnt - hs0, 1);
        check("single_latency_ok", int'((hs_cyc - t0) <= 52), 1);
        check("single_no_overrun", ovr_cnt, 0);

        // Back-to-back frames, no gap.
        hs0 = hs_cnt;
        exp_q.push_back(8'h73);
        exp_q.push_back(8'h77);
        send_bits(8'h73, 1'b1, 10);
        send_bits(8'h77, 1'b1, 10);
        wait_drained("b2b_drain", 40);
        check("b2b_count", hs_cnt - hs0, 2);

        // One-cycle glitch: no output.
        hs0 = hs_cnt;
        serial_in = 1'b0;
        @(posedge clk);
        #1;
        serial_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            seen = seen | data_out_valid;
        end
        #1;
        check("glitch_no_valid", int'(seen), 0);
        check("glitch_no_hs", hs_cnt - hs0, 0);

        // Overrun: hold ready low across two frames.
        data_out_ready = 1'b0;
        ovr0 = ovr_cnt;
        exp_q.push_back(8'h63);
        send_bits(8'h63, 1'b1, 10);
        send_bits(8'h64, 1'b1, 10);
        idle(10);
        check("ovr_data_held", int'(data_out), 8'h63);
        check("ovr_valid_held", int'(data_out_valid), 1);
        check("ovr_pulses", ovr_cnt - ovr0, 1);
        data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("ovr_valid_drop", int'(data_out_valid), 0);
        check("ovr_queue_empty", exp_q.size(), 0);

        // Low stop bit.
        hs0 = hs_cnt;
        fe0 = fe_cnt;
`ifdef UART_RX_FRAMING_CHECK_EN
        send_bits(8'h55, 1'b0, 10);
        idle(15);
        check("frm_pulse", fe_cnt - fe0, 1);
        check("frm_no_byte", hs_cnt - hs0, 0);
`else
        exp_q.push_back(8'h55);
        send_bits(8'h55, 1'b0, 10);
        idle(15);
        check("frm_delivered", hs_cnt - hs0, 1);
        check("frm_no_pulse", fe_cnt - fe0, 0);
`endif

        // Reset during data bit 4 of 8'hca, then a clean 8'h0d.
        hs0 = hs_cnt;
        send_bits(8'hca, 1'b1, 5);
        serial_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(20);
        check("rst_mid_nothing", hs_cnt - hs0, 0);
        exp_q.push_back(8'h0d);
        send_bits(8'h0d, 1'b1, 10);
        wait_drained("rst_then_0d", 20);
        check("rst_then_count", hs_cnt - hs0, 1);
        check("final_overrun", ovr_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
